// File: rtl/lu_pkg.sv
// Shared types and default geometry for the lu matrix controller slice.
package lu_pkg;

  localparam int LU_SIZE  = 32;
  localparam int LU_WIDTH = 64;
  localparam int LU_ROW_W = LU_SIZE * 2 * LU_WIDTH;
  localparam int LU_AW    = $clog2(LU_SIZE);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    RUN,
    DRAIN,
    RD_WAIT,
    PRESENT
  } state_e;

endpackage

// File: rtl/lu_row_ram.sv
// Single-port row store: synchronous write, registered read, array left unreset.
module lu_row_ram #(
  parameter int SIZE  = 32,
  parameter int ROW_W = 4096,
  parameter int AW    = 5
) (
  input  logic             clk_i,
  input  logic             en_i,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [ROW_W-1:0] wdata_i,
  output logic [ROW_W-1:0] rdata_o
);

  logic [ROW_W-1:0] mem_q [SIZE];
  logic [ROW_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lu_mat_ctrl.sv
// Job sequencer and single-port row-store arbiter between the host row stream and lu.
module lu_mat_ctrl
  import lu_pkg::*;
#(
  parameter int SIZE  = LU_SIZE,
  parameter int WIDTH = LU_WIDTH,
  localparam int ROW_W = SIZE * 2 * WIDTH,
  localparam int AW    = $clog2(SIZE)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             host_start_i,
  input  logic             host_flush_i,
  input  logic [ROW_W-1:0] host_wr_data_i,
  input  logic             host_wr_valid_i,
  output logic             host_wr_ready_o,
  output logic [ROW_W-1:0] host_rd_data_o,
  output logic             host_rd_valid_o,
  input  logic             host_rd_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             lu_start_o,
  output logic             lu_flush_o,
  input  logic             lu_busy_i,
  input  logic [AW-1:0]    lu_rd_addr_i,
  input  logic             lu_rd_addr_valid_i,
  output logic [ROW_W-1:0] lu_row_o,
  output logic             lu_row_valid_o,
  output logic [AW-1:0]    lu_row_addr_o,
  input  logic [ROW_W-1:0] lu_wr_row_i,
  input  logic             lu_wr_valid_i,
  input  logic [AW-1:0]    lu_wr_addr_i,
  output logic             lu_wr_ready_o
);

  localparam logic [AW:0] CNT_LAST = (AW+1)'(SIZE - 1);

  state_e           state_q, state_d;
  logic [AW:0]      cnt_q, cnt_d;
  logic             seen_busy_q, seen_busy_d;
  logic             done_q, done_d;
  logic             row_vld_q, row_vld_d;
  logic [AW-1:0]    row_addr_q, row_addr_d;
  logic [ROW_W-1:0] drain_q, drain_d;

  logic             ram_en, ram_we;
  logic [AW-1:0]    ram_addr;
  logic [ROW_W-1:0] ram_wdata, ram_rdata;
  logic             rd_fire, wr_fire;

  lu_row_ram #(.SIZE(SIZE), .ROW_W(ROW_W), .AW(AW)) u_ram (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Reads win the port outright; a write only lands in a cycle with no read.
  assign rd_fire = (state_q == RUN) && lu_rd_addr_valid_i;
  assign wr_fire = (state_q == RUN) && lu_wr_valid_i && !lu_rd_addr_valid_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seen_busy_d = seen_busy_q;
    done_d      = 1'b0;
    row_vld_d   = 1'b0;
    row_addr_d  = row_addr_q;
    drain_d     = drain_q;
    ram_en      = 1'b0;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = '0;

    case (state_q)
      IDLE: begin
        if (host_start_i) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        if (host_wr_valid_i) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = cnt_q[AW-1:0];
          ram_wdata = host_wr_data_i;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_d = START;
        end
      end
      START: state_d = RUN;
      RUN: begin
        seen_busy_d = seen_busy_q | lu_busy_i;
        if (rd_fire) begin
          ram_en     = 1'b1;
          ram_addr   = lu_rd_addr_i;
          row_vld_d  = 1'b1;
          row_addr_d = lu_rd_addr_i;
        end else if (wr_fire) begin
          ram_en    = 1'b1;
          ram_we    = 1'b1;
          ram_addr  = lu_wr_addr_i;
          ram_wdata = lu_wr_row_i;
        end
        // Hold RUN while a write-back is still landing so no update is lost.
        if (seen_busy_q && !lu_busy_i && !wr_fire) begin
          state_d     = DRAIN;
          cnt_d       = '0;
          seen_busy_d = 1'b0;
        end
      end
      DRAIN: begin
        ram_en   = 1'b1;
        ram_addr = cnt_q[AW-1:0];
        state_d  = RD_WAIT;
      end
      RD_WAIT: begin
        drain_d = ram_rdata;
        state_d = PRESENT;
      end
      PRESENT: begin
        if (host_rd_ready_i) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (host_flush_i) begin
      state_d     = IDLE;
      cnt_d       = '0;
      seen_busy_d = 1'b0;
      done_d      = 1'b0;
      row_vld_d   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      seen_busy_q <= 1'b0;
      done_q      <= 1'b0;
      row_vld_q   <= 1'b0;
      row_addr_q  <= '0;
      drain_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seen_busy_q <= seen_busy_d;
      done_q      <= done_d;
      row_vld_q   <= row_vld_d;
      row_addr_q  <= row_addr_d;
      drain_q     <= drain_d;
    end
  end

  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;
  assign host_wr_ready_o = (state_q == LOAD);
  assign host_rd_valid_o = (state_q == PRESENT);
  assign host_rd_data_o  = drain_q;
  assign lu_start_o      = (state_q == START);
  assign lu_flush_o      = host_flush_i && ((state_q == START) || (state_q == RUN));
  assign lu_wr_ready_o   = (state_q == RUN) && !lu_rd_addr_valid_i;
  // The RAM output is unreset, so keep it off the bus outside a valid beat.
  assign lu_row_o        = row_vld_q ? ram_rdata : '0;
  assign lu_row_valid_o  = row_vld_q;
  assign lu_row_addr_o   = row_addr_q;

endmodule

// File: doc/lu_mat_ctrl.md
# lu_mat_ctrl

Sequencer and memory arbiter for the `lu` decomposition core. It owns the single-port matrix row store and runs one job per start request:
- loads SIZE rows from the host;
- pulses `lu` start;
- services `lu` row reads and write-backs with the fixed one-cycle read latency `lu` expects;
- streams the updated matrix back to the host.

It sits between the host/DMA row stream and `lu`. L/U result outputs bypass this block.

## Interface
- SIZE, 32, matrix dimension; rows are 0..SIZE-1.
- WIDTH, 64, bits per real/imag part. Row width ROW_W = SIZE*2*WIDTH, packed {b,a} per element. AW = $clog2(SIZE).
- clk_i  in  1  clock.
- rst_ni  in  1  reset; one clock, asynchronous active-low reset.
- host_start_i  in  1  begin job; sampled only in IDLE.
- host_flush_i  in  1  abort job, any state.
- host_wr_data_i  in  ROW_W  load row.
- host_wr_valid_i / host_wr_ready_o  in/out  1  load handshake.
- host_rd_data_o  out  ROW_W  drained row.
- host_rd_valid_o / host_rd_ready_i  out/in  1  drain handshake.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse when the job completes.
- lu_start_o  out  1  one-cycle start pulse to `lu`.
- lu_flush_o  out  1  one-cycle flush pulse to `lu`.
- lu_busy_i  in  1  `lu` busy_o.
- lu_rd_addr_i  in  AW  `lu` read address.
- lu_rd_addr_valid_i  in  1  `lu` read address valid.
- lu_row_o  out  ROW_W  read data to `lu`.
- lu_row_valid_o  out  1  read data valid.
- lu_row_addr_o  out  AW  echoed read address.
- lu_wr_row_i  in  ROW_W  write-back row from `lu`.
- lu_wr_valid_i  in  1  write-back valid.
- lu_wr_addr_i  in  AW  write-back address.
- lu_wr_ready_o  out  1  write-back accept.

## Operation
- Reset values: all outputs 0, state IDLE, row counter 0, seen_busy 0.
- States and transitions:
  - IDLE: host_start_i -> LOAD.
  - LOAD: host_wr_ready_o=1. Each accepted row is written at the counter address, then the counter increments. Accepting row SIZE-1 -> START.
  - START: lu_start_o=1 for exactly one cycle -> RUN.
  - RUN: seen_busy is set when lu_busy_i=1. Exit to DRAIN when seen_busy=1, lu_busy_i=0, and no write handshake occurs that cycle.
  - DRAIN: issue a RAM read at counter -> RD_WAIT.
  - RD_WAIT: latch the data and set host_rd_valid_o -> PRESENT.
  - PRESENT: hold data until host_rd_ready_i. On accept, increment the counter. After row SIZE-1, pulse done_o -> IDLE; otherwise -> DRAIN.
- Arbitration in RUN (single port, one access per cycle):
  - A read has absolute priority; `lu` reads have no backpressure.
  - lu_wr_ready_o = (state==RUN) && !lu_rd_addr_valid_i. This is combinational.
  - A write and a read to the same address in the same cycle: the read returns the old data. The write lands on a later accept.
- Counter: AW+1 bits, cleared on entry to LOAD and on entry to DRAIN. No wrap-around is permitted.
- host_flush_i (highest priority, any state):
  - next state IDLE, counter cleared, seen_busy cleared;
  - lu_flush_o pulses one cycle, but only if the flush arrives in START or RUN;
  - no done_o is generated.
- host_start_i outside IDLE is ignored. lu_* inputs outside RUN are ignored, and lu_wr_ready_o=0 there.
- Asynchronous reset mid-job: all state is discarded immediately. RAM contents are undefined.

## Timing
- `lu` read: address valid at cycle t -> lu_row_o, lu_row_addr_o=addr and lu_row_valid_o=1 at t+1. One read per cycle is sustained.
- Write-back: written to the RAM on the cycle of the handshake.
- Load: one row per cycle. lu_start_o is asserted the cycle after the last load accept.
- Drain: one row per 3 cycles at best. host_rd_data_o stays stable while valid && !ready.
- done_o: asserted the cycle after the last drain accept, coincident with state IDLE.

## Structure
- Package `lu_pkg`:
  - state enum (IDLE, LOAD, START, RUN, DRAIN, RD_WAIT, PRESENT);
  - ROW_W and AW as localparams derived from SIZE/WIDTH.
- Sub-module `lu_row_ram`:
  - SIZE x ROW_W, one read/write port;
  - synchronous write; registered read with 1-cycle latency;
  - no reset on the array.
- The FSM, arbiter mux and drain register live in lu_mat_ctrl.

## Test plan
Bench configuration: SIZE=4, WIDTH=64.
- Reset: hold rst_ni=0 mid-LOAD -> every output is 0 immediately. After release, host_wr_ready_o=0 until host_start_i.
- Load: start, then 4 back-to-back rows 0x11..,0x22..,0x33..,0x44.. -> 4 accepts in 4 cycles, then lu_start_o=1 for exactly 1 cycle on the next cycle.
- Read latency: lu_rd_addr_i=2 with valid at t -> at t+1, lu_row_o=0x33.., lu_row_addr_o=2, lu_row_valid_o=1. Back-to-back reads of 0,1,3 -> 3 consecutive valid beats.
- Collision:
  - read addr 3 + write addr 3 (data 0xAA..) in the same cycle -> lu_wr_ready_o=0 and the read returns 0x44..;
  - write accepted next cycle; a later read of 3 returns 0xAA...
- Completion: lu_busy_i high 10 cycles then low; host_rd_ready_i toggling 1,0,1,... -> rows 0..3 are drained in order with data stable while stalled. done_o pulses once; busy_o=0 afterwards.
- Flush: host_flush_i in RUN -> lu_flush_o pulses 1 cycle, state IDLE next cycle, no done_o. A later start reloads and runs normally.
